// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Build option FETCH_BRANCH_REL_EN selects relative (signed 8-bit offset)
// branch-target LUT entries instead of absolute PC addresses.
package fetch_pkg;

  localparam int DEF_PC_W      = 10;
  localparam int DEF_MCODE_W   = 9;
  localparam int DEF_LUT_IDX_W = 4;
  localparam int LUT_DEPTH     = 16;

  // Halt ends the program; bubble is a harmless no-write encoding.
  localparam logic [DEF_MCODE_W-1:0] HALT_INSTR   = 9'b111_11_1111;
  localparam logic [DEF_MCODE_W-1:0] BUBBLE_INSTR = 9'b000_11_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

`ifdef FETCH_BRANCH_REL_EN
  typedef logic signed [7:0] lut_entry_t;
`else
  typedef logic [DEF_PC_W-1:0] lut_entry_t;
`endif

  typedef lut_entry_t [LUT_DEPTH-1:0] lut_table_t;

  // Default ROM image used when the integrator supplies none.
  function automatic lut_table_t default_lut();
    lut_table_t t;
    for (int i = 0; i < LUT_DEPTH; i++) begin
`ifdef FETCH_BRANCH_REL_EN
      t[i] = lut_entry_t'(i - 5);
`else
      t[i] = lut_entry_t'(i * 32);
`endif
    end
    return t;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target ROM: index -> entry.
// Contents come in through the TABLE parameter (the image that would
// otherwise live in branch_lut.hex). Entry format follows
// FETCH_BRANCH_REL_EN via lut_entry_t.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int         IDX_W = DEF_LUT_IDX_W,
  parameter lut_table_t TABLE = default_lut()
) (
  input  logic [IDX_W-1:0] idx_i,
  output lut_entry_t       entry_o
);

  assign entry_o = TABLE[idx_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the synchronous instruction
// memory, presents one word per cycle with a valid flag, redirects on taken
// branches through branch_lut and stops on the halt encoding.
// Build option FETCH_BRANCH_REL_EN: LUT entries are PC-relative offsets.
//
// Flow control: there is no valid/ready pair. instr_valid qualifies instr
// in every cycle; stall is the only back-pressure and, while high, freezes
// state, PC and all outputs (the presented word is kept in hold_q because
// the memory keeps re-reading the next address).
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int         PC_W      = DEF_PC_W,
  parameter int         MCODE_W   = DEF_MCODE_W,
  parameter int         LUT_IDX_W = DEF_LUT_IDX_W,
  parameter lut_table_t LUT_INIT  = default_lut()
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch,
  input  logic               take_branch,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [MCODE_W-1:0] imem_data,
  output logic [MCODE_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    instr_pc,
  output logic               done,
  output fetch_state_t       dbg_state
);

  fetch_state_t       state_q, state_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               held_q;
  logic [MCODE_W-1:0] hold_q;
  logic [PC_W-1:0]    target;
  lut_entry_t         lut_entry;
  logic               is_halt;
  logic               take;

  branch_lut #(
    .IDX_W (LUT_IDX_W),
    .TABLE (LUT_INIT)
  ) u_lut (
    .idx_i   (instr[LUT_IDX_W-1:0]),
    .entry_o (lut_entry)
  );

`ifdef FETCH_BRANCH_REL_EN
  assign target = pc_q + {{(PC_W-8){lut_entry[7]}}, lut_entry};
`else
  assign target = PC_W'(lut_entry);
`endif

  assign is_halt = valid_q && (instr == MCODE_W'(HALT_INSTR));
  assign take    = valid_q && branch && take_branch;

  // Word to decoder: bubble when invalid, captured word while stalled.
  always_comb begin
    instr = MCODE_W'(BUBBLE_INSTR);
    if (valid_q) begin
      if (held_q) instr = hold_q;
      else        instr = imem_data;
    end
  end

  // Next-state, next-PC and flag logic; nothing moves while stalled.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (!stall) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_PRIME;
            addr_d  = '0;
            done_d  = 1'b0;
            valid_d = 1'b0;
          end
        end
        ST_PRIME: begin
          state_d = ST_RUN;
          pc_d    = addr_q;
          addr_d  = addr_q + PC_W'(1);
          valid_d = 1'b1;
        end
        ST_RUN: begin
          if (is_halt) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            valid_d = 1'b0;
          end else if (take) begin
            // The word already in flight is squashed.
            pc_d    = addr_q;
            addr_d  = target;
            valid_d = 1'b0;
          end else begin
            pc_d    = addr_q;
            addr_d  = addr_q + PC_W'(1);
            valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Capture the presented word on the first stalled edge so instr stays put.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      held_q <= 1'b0;
      hold_q <= '0;
    end else begin
      held_q <= stall;
      if (stall && !held_q) hold_q <= imem_data;
    end
  end

  assign imem_addr   = addr_q;
  assign instr_pc    = pc_q;
  assign instr_valid = valid_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written corner-case
// sequences and a randomized run against a program-level reference model.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam logic [8:0] TB_HALT   = 9'h1FF;
  localparam logic [8:0] TB_BUBBLE = 9'h030;

  // LUT value for index idx: absolute address or signed offset.
  function automatic int lut_val(input int idx);
`ifdef FETCH_BRANCH_REL_EN
    return (idx == 2) ? -3 : (idx * 13 - 90);
`else
    return (idx == 2) ? 64 : ((idx * 57 + 100) % 1024);
`endif
  endfunction

  function automatic lut_table_t build_lut();
    lut_table_t t;
    for (int i = 0; i < 16; i++) t[i] = lut_entry_t'(lut_val(i));
    return t;
  endfunction

  localparam lut_table_t TB_LUT = build_lut();

  function automatic logic [9:0] tb_target(input logic [9:0] pc, input int idx);
`ifdef FETCH_BRANCH_REL_EN
    return 10'((int'(pc) + lut_val(idx) + 1024) % 1024);
`else
    return 10'(lut_val(idx));
`endif
  endfunction

  logic       Clk, Reset_n, start, stall, branch, take_branch;
  logic [9:0] imem_addr, instr_pc;
  logic [8:0] imem_data, instr;
  logic       instr_valid, done;
  logic [1:0] dbg_state;
  logic [8:0] mem [0:1023];

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch #(.LUT_INIT(TB_LUT)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .start       (start),
    .stall       (stall),
    .branch      (branch),
    .take_branch (take_branch),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // Clock / memory
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) imem_data <= mem[imem_addr];

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  // Driver / checker tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 1024; i++) mem[i] = 9'(i % 256);
  endtask

  task automatic do_reset();
    start = 0; stall = 0; branch = 0; take_branch = 0;
    Reset_n = 0;
    #3;
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_done", done, 0);
    chk("rst_instr", instr, TB_BUBBLE);
    @(negedge Clk);
    Reset_n = 1;
  endtask

  task automatic start_prog();
    start = 1;
    step();
    start = 0;
  endtask

  task automatic run_to_pc(input logic [9:0] pc, input int budget);
    int found = 0;
    for (int i = 0; i < budget && found == 0; i++) begin
      if (instr_valid && instr_pc == pc) found = 1;
      else step();
    end
    chk($sformatf("reach_pc_%0h", pc), found, 1);
  endtask

  // Directed vector table
  typedef struct {
    logic       start, stall, branch, take;
    logic       exp_valid;
    logic [9:0] exp_pc, exp_addr;
    logic [8:0] exp_instr;
    logic       exp_done;
  } vec_t;

  function automatic vec_t mk(input logic s, st, b, t, v, input logic [9:0] pc,
                              input logic [9:0] a, input logic [8:0] ins, input logic d);
    vec_t r;
    r.start = s; r.stall = st; r.branch = b; r.take = t;
    r.exp_valid = v; r.exp_pc = pc; r.exp_addr = a; r.exp_instr = ins; r.exp_done = d;
    return r;
  endfunction

  // Reference model: program-level view of what is presented each cycle
  int         m_mode;   // 0 idle, 1 priming, 2 running, 3 finished
  bit         m_valid, m_done;
  logic [9:0] m_pc, m_addr;

  task automatic model_reset();
    m_mode = 0; m_valid = 0; m_done = 0; m_pc = 0; m_addr = 0;
  endtask

  task automatic model_edge(input bit s, st, b, t);
    logic [9:0] tgt;
    if (st) return;
    if (m_mode == 0 || m_mode == 3) begin
      if (s) begin m_mode = 1; m_addr = 0; m_done = 0; m_valid = 0; end
    end else if (m_mode == 1) begin
      m_mode = 2; m_valid = 1; m_pc = m_addr; m_addr = m_addr + 10'd1;
    end else begin
      if (m_valid && mem[m_pc] == TB_HALT) begin
        m_mode = 3; m_done = 1; m_valid = 0;
      end else if (m_valid && b && t) begin
        tgt = tb_target(m_pc, int'(mem[m_pc][3:0]));
        m_valid = 0; m_pc = m_addr; m_addr = tgt;
      end else begin
        m_valid = 1; m_pc = m_addr; m_addr = m_addr + 10'd1;
      end
    end
  endtask

  initial begin
    vec_t       vt [14];
    logic [9:0] tgt;

    // ---- directed table: start, halt, restart from DONE, stalls ----
    fill_seq();
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = TB_HALT;
    //            st  sl br tk  v  pc  addr instr      done
    vt[0]  = mk(1, 0, 0, 0, 0, 0, 0, TB_BUBBLE, 0);
    vt[1]  = mk(0, 0, 0, 0, 1, 0, 1, 9'h001,    0);
    vt[2]  = mk(0, 0, 0, 0, 1, 1, 2, 9'h002,    0);
    vt[3]  = mk(1, 0, 0, 0, 1, 2, 3, 9'h003,    0);
    vt[4]  = mk(0, 0, 0, 0, 1, 3, 4, TB_HALT,   0);
    vt[5]  = mk(0, 0, 1, 1, 0, 0, 4, TB_BUBBLE, 1);
    vt[6]  = mk(0, 0, 0, 0, 0, 0, 4, TB_BUBBLE, 1);
    vt[7]  = mk(1, 0, 0, 0, 0, 0, 0, TB_BUBBLE, 0);
    vt[8]  = mk(0, 1, 0, 0, 0, 0, 0, TB_BUBBLE, 0);
    vt[9]  = mk(0, 0, 0, 0, 1, 0, 1, 9'h001,    0);
    vt[10] = mk(0, 1, 0, 0, 1, 0, 1, 9'h001,    0);
    vt[11] = mk(0, 1, 1, 1, 1, 0, 1, 9'h001,    0);
    vt[12] = mk(0, 0, 0, 0, 1, 1, 2, 9'h002,    0);
    vt[13] = mk(0, 0, 0, 0, 1, 2, 3, 9'h003,    0);
    do_reset();
    for (int i = 0; i < 14; i++) begin
      start = vt[i].start; stall = vt[i].stall;
      branch = vt[i].branch; take_branch = vt[i].take;
      step();
      chk($sformatf("v%0d_valid", i), instr_valid, vt[i].exp_valid);
      chk($sformatf("v%0d_addr", i), imem_addr, vt[i].exp_addr);
      chk($sformatf("v%0d_instr", i), instr, vt[i].exp_instr);
      chk($sformatf("v%0d_done", i), done, vt[i].exp_done);
      if (vt[i].exp_valid) chk($sformatf("v%0d_pc", i), instr_pc, vt[i].exp_pc);
    end
    start = 0; stall = 0; branch = 0; take_branch = 0;

    // ---- taken branch at PC 5, index 2; branch ignored during bubble ----
    fill_seq();
    mem[5] = 9'h012;
    tgt = tb_target(10'd5, 2);
    do_reset();
    start_prog();
    run_to_pc(10'd5, 20);
    chk("br_instr", instr, 9'h012);
    branch = 1; take_branch = 1;
    step();
    chk("br_bubble_valid", instr_valid, 0);
    chk("br_bubble_instr", instr, TB_BUBBLE);
    chk("br_addr", imem_addr, tgt);
    step();
    branch = 0; take_branch = 0;
    chk("br_tgt_valid", instr_valid, 1);
    chk("br_tgt_pc", instr_pc, tgt);
    chk("br_tgt_instr", instr, mem[tgt]);
    step();
    chk("br_tgt1_pc", instr_pc, tgt + 10'd1);

    // ---- not-taken branch, then stall at PC 7 ----
    do_reset();
    start_prog();
    run_to_pc(10'd5, 20);
    branch = 1; take_branch = 0;
    step();
    branch = 0;
    chk("nt_valid", instr_valid, 1);
    chk("nt_pc", instr_pc, 6);
    step();
    chk("st_pc_pre", instr_pc, 7);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("st%0d_pc", i), instr_pc, 7);
      chk($sformatf("st%0d_instr", i), instr, mem[7]);
      chk($sformatf("st%0d_addr", i), imem_addr, 8);
      chk($sformatf("st%0d_valid", i), instr_valid, 1);
    end
    stall = 0;
    step();
    chk("st_after_pc", instr_pc, 8);
    chk("st_after_instr", instr, mem[8]);

    // ---- PC wrap through 0x3FF ----
    run_to_pc(10'h3FF, 1100);
    step();
    chk("wrap_valid", instr_valid, 1);
    chk("wrap_pc", instr_pc, 0);
    chk("wrap_done", done, 0);

    // ---- asynchronous reset mid-run at PC 20, then refetch ----
    run_to_pc(10'd20, 40);
    Reset_n = 0;
    #1;
    chk("ar_addr", imem_addr, 0);
    chk("ar_valid", instr_valid, 0);
    chk("ar_pc", instr_pc, 0);
    chk("ar_instr", instr, TB_BUBBLE);
    chk("ar_done", done, 0);
    @(negedge Clk);
    Reset_n = 1;
    start_prog();
    step();
    chk("ar_restart_valid", instr_valid, 1);
    chk("ar_restart_pc", instr_pc, 0);

    // ---- randomized run against the reference model ----
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 39) == 0) ? TB_HALT : 9'($urandom_range(0, 510));
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      start       = ($urandom_range(0, 7) == 0);
      stall       = ($urandom_range(0, 3) == 0);
      branch      = ($urandom_range(0, 2) == 0);
      take_branch = 1'($urandom_range(0, 1));
      model_edge(start, stall, branch, take_branch);
      step();
      chk("rnd_valid", instr_valid, m_valid);
      chk("rnd_addr", imem_addr, m_addr);
      chk("rnd_done", done, m_done);
      chk("rnd_instr", instr, m_valid ? mem[m_pc] : TB_BUBBLE);
      if (m_valid) chk("rnd_pc", instr_pc, m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
